// File: rtl/decode_stage.sv
// Purpose: RV32I/M decode stage; buffers {instr, pc} from fetch in a DEPTH-entry queue and decodes the head into a registered slot.
// Latency: one cycle from acceptance to OUT_VALID when the queue is empty and the slot is free; one instruction per cycle sustained.
// Backpressure: IN_READY drops when the queue is full; the slot holds while OUT_VALID & ~OUT_READY; FLUSH empties everything.
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INSTR,
  input  logic [PC_W-1:0] IN_PC,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [5:0]      OUT_OP_ID,
  output logic            OUT_ILLEGAL,
  output logic [4:0]      OUT_RS1,
  output logic [4:0]      OUT_RS2,
  output logic [4:0]      OUT_RD,
  output logic [31:0]     OUT_IMM,
  output logic [PC_W-1:0] OUT_PC
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [5:0]  op_id;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } dec_t;

  logic [31:0]     mem_instr_q [DEPTH];
  logic [31:0]     mem_instr_d [DEPTH];
  logic [PC_W-1:0] mem_pc_q    [DEPTH];
  logic [PC_W-1:0] mem_pc_d    [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            vld_q, vld_d;
  dec_t            dec_q, dec_d, dec_head;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            push, pop;
  logic [31:0]     head;

  assign IN_READY = (count_q < DEPTH_C);
  assign push     = IN_VALID & IN_READY & ~FLUSH;
  assign pop      = (count_q != '0) & (~vld_q | OUT_READY);
  assign head     = mem_instr_q[rd_ptr_q];

  // Combinational decode of the queue head into op id, register indices and immediate.
  always_comb begin
    logic        legal, use_rs1, use_rs2, use_rd;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    dec_head = '0;
    legal    = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    op       = 6'd0;
    imm      = '0;
    f3       = head[14:12];
    f7       = head[31:25];
    case (head[6:0])
      7'b0110111: begin legal = 1'b1; op = 6'd0; use_rd = 1'b1; imm = {head[31:12], 12'b0}; end
      7'b0010111: begin legal = 1'b1; op = 6'd1; use_rd = 1'b1; imm = {head[31:12], 12'b0}; end
      7'b1101111: begin
        legal = 1'b1; op = 6'd2; use_rd = 1'b1;
        imm = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      end
      7'b1100111: begin
        legal = (f3 == 3'b000); op = 6'd3; use_rd = 1'b1; use_rs1 = 1'b1;
        imm = {{20{head[31]}}, head[31:20]};
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; legal = 1'b1;
        imm = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
        case (f3)
          3'b000: op = 6'd4;
          3'b001: op = 6'd5;
          3'b100: op = 6'd6;
          3'b101: op = 6'd7;
          3'b110: op = 6'd8;
          3'b111: op = 6'd9;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; legal = 1'b1;
        imm = {{20{head[31]}}, head[31:20]};
        case (f3)
          3'b000: op = 6'd10;
          3'b001: op = 6'd11;
          3'b010: op = 6'd12;
          3'b100: op = 6'd13;
          3'b101: op = 6'd14;
          default: legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; legal = 1'b1;
        imm = {{20{head[31]}}, head[31:25], head[11:7]};
        case (f3)
          3'b000: op = 6'd15;
          3'b001: op = 6'd16;
          3'b010: op = 6'd17;
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        use_rs1 = 1'b1; use_rd = 1'b1; legal = 1'b1;
        imm = {{20{head[31]}}, head[31:20]};
        case (f3)
          3'b000: op = 6'd18;
          3'b010: op = 6'd19;
          3'b011: op = 6'd20;
          3'b100: op = 6'd21;
          3'b110: op = 6'd22;
          3'b111: op = 6'd23;
          3'b001: begin op = 6'd24; legal = (f7 == 7'b0000000); end
          3'b101: begin
            op    = (f7 == 7'b0100000) ? 6'd26 : 6'd25;
            legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          end
          default: legal = 1'b0;
        endcase
      end
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        if (f7 == 7'b0000000) begin
          legal = 1'b1;
          case (f3)
            3'b000: op = 6'd27;
            3'b001: op = 6'd29;
            3'b010: op = 6'd30;
            3'b011: op = 6'd31;
            3'b100: op = 6'd32;
            3'b101: op = 6'd33;
            3'b110: op = 6'd35;
            default: op = 6'd36;
          endcase
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101);
          op    = (f3 == 3'b000) ? 6'd28 : 6'd34;
        end else if (f7 == 7'b0000001) begin
          legal = EN_M;
          op    = 6'd37 + {3'b000, f3};
        end
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec_head.op_id = op;
      dec_head.rs1   = use_rs1 ? head[19:15] : 5'd0;
      dec_head.rs2   = use_rs2 ? head[24:20] : 5'd0;
      dec_head.rd    = use_rd  ? head[11:7]  : 5'd0;
      dec_head.imm   = imm;
    end else begin
      dec_head.op_id   = 6'd63;
      dec_head.illegal = 1'b1;
    end
  end

  // Next-state for queue pointers, storage and the output slot; flush overrides push/pop.
  always_comb begin
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    vld_d       = vld_q;
    dec_d       = dec_q;
    pc_d        = pc_q;
    if (push) begin
      mem_instr_d[wr_ptr_q] = IN_INSTR;
      mem_pc_d[wr_ptr_q]    = IN_PC;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      vld_d    = 1'b1;
      dec_d    = dec_head;
      pc_d     = mem_pc_q[rd_ptr_q];
    end else if (OUT_READY) begin
      vld_d = 1'b0;
    end
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    if (FLUSH) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      vld_d    = 1'b0;
    end
  end

  // Control and output-slot registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= 1'b0;
      dec_q    <= '0;
      pc_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      dec_q    <= dec_d;
      pc_q     <= pc_d;
    end
  end

  // Queue storage; contents are only read when count is nonzero, so no reset.
  always_ff @(posedge CLK) begin
    mem_instr_q <= mem_instr_d;
    mem_pc_q    <= mem_pc_d;
  end

  assign OUT_VALID   = vld_q;
  assign OUT_OP_ID   = dec_q.op_id;
  assign OUT_ILLEGAL = dec_q.illegal;
  assign OUT_RS1     = dec_q.rs1;
  assign OUT_RS2     = dec_q.rs2;
  assign OUT_RD      = dec_q.rd;
  assign OUT_IMM     = dec_q.imm;
  assign OUT_PC      = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Purpose: directed bench for decode_stage with a scoreboard of expected decodes.
// Latency: expectations queued at input handshake, compared at output handshake.
// Backpressure: exercises full queue, held slot, flush and mid-stream reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, out_illegal;
  logic [5:0]  out_op_id;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;
  logic        nm_in_ready, nm_out_valid, nm_out_illegal;
  logic [5:0]  nm_out_op_id;
  logic [4:0]  nm_out_rs1, nm_out_rs2, nm_out_rd;
  logic [31:0] nm_out_imm, nm_out_pc;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(32), .DEPTH(2), .EN_M(1'b1)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_INSTR(in_instr),
    .IN_PC(in_pc), .FLUSH(flush), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_OP_ID(out_op_id), .OUT_ILLEGAL(out_illegal), .OUT_RS1(out_rs1), .OUT_RS2(out_rs2),
    .OUT_RD(out_rd), .OUT_IMM(out_imm), .OUT_PC(out_pc));

  decode_stage #(.PC_W(32), .DEPTH(2), .EN_M(1'b0)) dut_nm (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(nm_in_ready), .IN_INSTR(in_instr),
    .IN_PC(in_pc), .FLUSH(flush), .OUT_VALID(nm_out_valid), .OUT_READY(out_ready),
    .OUT_OP_ID(nm_out_op_id), .OUT_ILLEGAL(nm_out_illegal), .OUT_RS1(nm_out_rs1), .OUT_RS2(nm_out_rs2),
    .OUT_RD(nm_out_rd), .OUT_IMM(nm_out_imm), .OUT_PC(nm_out_pc));

  typedef struct {
    logic [5:0]  op;
    logic        ill;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   tests = 0;
  int   fails = 0;
  int   n_acc = 0;
  int   n_out = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping at the falling edge, then advance past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      n_out++;
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL sb_underflow observed=output_pc_%0h expected=no_output", out_pc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_dec", {out_op_id, out_illegal, out_rs1, out_rs2, out_rd, out_imm},
                         {e.op, e.ill, e.rs1, e.rs2, e.rd, e.imm});
        check("out_pc", {32'd0, out_pc}, {32'd0, e.pc});
      end
    end
    if (!rst && !flush && in_valid && in_ready) begin
      sb.push_back(pend);
      n_acc++;
    end
    if (rst || flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [5:0] op,
                       input logic ill, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    pend.op   = op;
    pend.ill  = ill;
    pend.rs1  = rs1;
    pend.rs2  = rs2;
    pend.rd   = rd;
    pend.imm  = imm;
    pend.pc   = pc;
  endtask

  // Push one instruction into an idle pipe; it must appear exactly one edge after acceptance.
  task automatic send_one(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [5:0] op, input logic ill, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
    drive(instr, pc, op, ill, rs1, rs2, rd, imm);
    cycle();
    in_valid = 1'b0;
    check({tag, "_lat0"}, {63'd0, out_valid}, 64'd0);
    cycle();
    check({tag, "_lat1"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic drive_addi(input int i, input logic [31:0] pc_base);
    logic [11:0] im;
    logic [4:0]  rd;
    im = 12'(i);
    rd = 5'(i + 1);
    drive({im, 5'd0, 3'b000, rd, 7'h13}, pc_base + 32'(4 * i), 6'd18, 1'b0, 5'd0, 5'd0, rd, {20'd0, im});
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_fields", {out_op_id, out_illegal, out_rs1, out_rs2, out_rd, out_imm}, 64'd0);
    check("rst_pc", {32'd0, out_pc}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    out_ready = 1'b1;
    send_one("addi", 32'hFFF10093, 32'h100, 6'd18, 1'b0, 5'd2, 5'd0, 5'd1, 32'hFFFFFFFF);
    check("addi_pc", {32'd0, out_pc}, 64'h100);
    cycle();
    send_one("beq", 32'hFE208EE3, 32'h104, 6'd4, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC);
    cycle();
    send_one("mul", 32'h022081B3, 32'h108, 6'd37, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    check("mul_nom_illegal", {57'd0, nm_out_op_id, nm_out_illegal}, {57'd0, 6'd63, 1'b1});
    check("mul_nom_fields", {nm_out_rs1, nm_out_rs2, nm_out_rd, nm_out_imm}, 64'd0);
    cycle();
    send_one("slli_bad", 32'h40109093, 32'h10C, 6'd63, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0);
    cycle();
    send_one("lui", 32'h123452B7, 32'h110, 6'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    cycle();
    send_one("jal", 32'hFF9FF0EF, 32'h114, 6'd2, 1'b0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFF8);
    cycle();
    send_one("sw", 32'h00512423, 32'h118, 6'd17, 1'b0, 5'd2, 5'd5, 5'd0, 32'd8);
    cycle();
    send_one("ecall", 32'h00000073, 32'h11C, 6'd63, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0);
    cycle();
    send_one("rvc", 32'h00004501, 32'h120, 6'd63, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0);
    cycle();

    // Backpressure: four offered, three fit (slot + two queue entries).
    out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 4; i++) begin
      drive_addi(i, 32'h200);
      cycle();
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(n_acc - base), 64'd3);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_slot", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h200});
    out_ready = 1'b1;
    base = n_out;
    cycle(); cycle(); cycle();
    check("bp_drain_rate", 64'(n_out - base), 64'd3);
    check("bp_drained", {63'd0, out_valid}, 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with the queue full and a push offered in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_addi(i + 4, 32'h300);
      cycle();
    end
    check("fl_full", {62'd0, out_valid, in_ready}, {62'd0, 2'b10});
    drive(32'h00700393, 32'h3FC, 6'd18, 1'b0, 5'd0, 5'd0, 5'd7, 32'd7);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_state", {62'd0, out_valid, in_ready}, {62'd0, 2'b01});
    out_ready = 1'b1;
    cycle();
    check("fl_no_stale", {63'd0, out_valid}, 64'd0);

    // Flush while the slot is consumed and a push would otherwise be accepted.
    send_one("pre_fl", 32'h00A00513, 32'h400, 6'd18, 1'b0, 5'd0, 5'd0, 5'd10, 32'd10);
    drive(32'h00B00593, 32'h404, 6'd18, 1'b0, 5'd0, 5'd0, 5'd11, 32'd11);
    flush = 1'b1;
    base = n_out;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_consumed", 64'(n_out - base), 64'd1);
    cycle();
    check("fl_drop", {63'd0, out_valid}, 64'd0);
    send_one("post_fl", 32'h00C00613, 32'h408, 6'd18, 1'b0, 5'd0, 5'd0, 5'd12, 32'd12);
    cycle();

    // Reset mid-stream with entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_addi(i + 8, 32'h500);
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_fields", {out_op_id, out_illegal, out_rs1, out_rs2, out_rd, out_imm}, 64'd0);
    check("mrst_pc", {32'd0, out_pc}, 64'd0);
    check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    cycle(); cycle();
    check("mrst_no_stale", {63'd0, out_valid}, 64'd0);
    send_one("post_rst", 32'h0020C1B3, 32'h600, 6'd32, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    cycle();
    cycle();
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
